sliced_sub32: RTL and testbench

- Multi-cycle subtractor: computes A − B over WIDTH bits using one SLICE-bit ripple slice per clock, with the carry held in a register between slices.
- Inverse operation of the 3-bit adder partitions in the adder32 flow. Used as the golden/inverse checker and as the recovery path for approximated adder outputs.
- Subtraction is done as A + ~B + 1. The slice carry-out is reported active-low, matching the adder slice's inverted carry port, so it reads directly as "borrow".

---
 rtl/sliced_sub32.sv | 120 ++++++++++++
 tb/tb_sliced_sub32.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sliced_sub32.sv
// Multi-cycle subtractor: computes a - b as a + ~b + 1, one SLICE-bit ripple
// slice per clock, with the inter-slice carry held in a register.
module sliced_sub32 #(
  parameter int WIDTH = 32,
  parameter int SLICE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] SLICE_MASK = {{(WIDTH-SLICE){1'b0}}, {SLICE{1'b1}}};

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and valid never waits on ready.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, nb_reg;
  logic [KW-1:0]    k;
  logic             carry;

  logic             accept, last_slice;
  int               sh;
  logic [WIDTH-1:0] a_sh, nb_sh, res_next;
  logic [SLICE-1:0] sum_bits;
  logic             c, carry_next, ovf_next;

  assign accept     = in_valid && (state == IDLE);
  assign last_slice = (k == KW'(NSLICE - 1));

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One ripple slice; bits past WIDTH in a partial last slice are skipped so
  // the carry out comes from bit WIDTH-1.
  always_comb begin
    sh       = int'(k) * SLICE;
    a_sh     = a_reg >> sh;
    nb_sh    = nb_reg >> sh;
    c        = carry;
    sum_bits = '0;
    for (int i = 0; i < SLICE; i++) begin
      if (sh + i < WIDTH) begin
        sum_bits[i] = a_sh[i] ^ nb_sh[i] ^ c;
        c = (a_sh[i] & nb_sh[i]) | (c & (a_sh[i] ^ nb_sh[i]));
      end
    end
    carry_next = c;
    res_next   = (diff & ~(SLICE_MASK << sh)) | (WIDTH'(sum_bits) << sh);
    ovf_next   = (a_reg[WIDTH-1] ^ ~nb_reg[WIDTH-1]) & (res_next[WIDTH-1] ^ a_reg[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      nb_reg <= '0;
      k      <= '0;
      carry  <= 1'b1;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg  <= a;
            nb_reg <= ~b;
            carry  <= 1'b1;
            k      <= '0;
          end
        end
        RUN: begin
          diff  <= res_next;
          carry <= carry_next;
          k     <= k + KW'(1);
          if (last_slice) begin
            borrow <= ~carry_next;
            ovf    <= ovf_next;
            k      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sliced_sub32.sv
// Bench for sliced_sub32: directed vector table, back-pressure and mid-run
// reset sequences, then randomized operands against an arithmetic model.
module tb_sliced_sub32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        borrow;
  logic        ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [33:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
  } vec_t;

  sliced_sub32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction and comparison, packed {borrow, ovf, diff}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
    longint dx, dy;
    logic [31:0] d;
    logic br, ov;
    dx = longint'(x);
    dy = longint'(y);
    d  = 32'(dx - dy);
    br = (dx < dy);
    ov = (x[31] != y[31]) && (d[31] != x[31]);
    return {br, ov, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation; bp cycles of out_ready=0 in DONE with stray in_valid pulses.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int bp);
    int n;
    int lat;
    logic [33:0] e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_op", {63'd0, in_ready}, 64'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    exp_q.push_back(model(av, bv));
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'd12);
    e = exp_q.pop_front();
    if (!out_valid) return;
    for (int i = 0; i < bp; i++) begin
      chk("bp_hold_result", {30'd0, borrow, ovf, diff}, {30'd0, e});
      chk("bp_in_ready_low", {62'd0, in_ready, out_valid}, 64'd1);
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("result", {30'd0, borrow, ovf, diff}, {30'd0, e});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_handshake", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h0FED_CBA9, 32'h0246_8ACF, 1'b0, 1'b0};

    do_reset();
    chk("reset_ctrl", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'h8);
    chk("reset_data", {30'd0, borrow, ovf, diff}, 64'd0);

    // Directed table; the model must agree with the hand-computed entries.
    for (int i = 0; i < 6; i++) begin
      chk("table_model", 64'(model(vecs[i].a, vecs[i].b)),
          64'({vecs[i].borrow, vecs[i].ovf, vecs[i].diff}));
      do_op(vecs[i].a, vecs[i].b, 0);
    end

    // Back-pressure for 5 cycles, then the next operand must be accepted.
    do_op(32'hCAFE_0001, 32'h0000_0F00, 5);
    do_op(32'h0000_0010, 32'h0000_0020, 0);

    // Reset arriving while slice 6 is being processed.
    @(negedge clk);
    a = 32'h1234_5678;
    b = 32'h0FED_CBA9;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrun_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset_ctrl", {61'd0, in_ready, out_valid, busy}, 64'h4);
    chk("midrun_reset_diff", {32'd0, diff}, 64'd0);
    repeat (14) begin
      chk("midrun_no_output", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
    end
    do_op(32'h1234_5678, 32'h0FED_CBA9, 0);

    // Randomized background with occasional back-pressure and corner operands.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = '1;
        2: rb = ra;
        3: ra = {1'b1, 31'd0};
        default: ;
      endcase
      do_op(ra, rb, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
